// File: rtl/gol_pkg.sv
// Shared types and helpers for the Game-of-Life monitor.
// Status encoding and population width.
package gol_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DEAD  = 3'd2,
    STILL = 3'd3,
    OSC2  = 3'd4
  } status_t;

  function automatic int pop_w(
    input int rows,
    input int cols
  );
    return $clog2(rows * cols + 1);
  endfunction

  function automatic logic is_term(
    input status_t s
  );
    return (s == DEAD) || (s == STILL) ||
           (s == OSC2);
  endfunction

endpackage

// File: rtl/gol_monitor_popcount.sv
// Combinational live-cell counter.
// Pairwise adder tree over the flattened grid.
module gol_popcount
  import gol_pkg::*;
#(
  parameter int ROWS = 3,
  parameter int COLS = 3
) (
  input  logic [ROWS*COLS-1:0]           bits,
  output logic [pop_w(ROWS,COLS)-1:0]    count
);

  localparam int N  = ROWS * COLS;
  localparam int W  = pop_w(ROWS, COLS);
  localparam int LV = $clog2(N);
  localparam int W2 = 1 << LV;

  logic [W2-1:0] pad;
  logic [W-1:0]  node [LV+1][W2];

  assign pad = W2'(bits);

  // Leaves are single cells; each level sums pairs.
  always_comb begin
    for (int l = 0; l <= LV; l++) begin
      for (int i = 0; i < W2; i++) begin
        node[l][i] = '0;
      end
    end
    for (int i = 0; i < W2; i++) begin
      node[0][i] = W'(pad[i]);
    end
    for (int l = 0; l < LV; l++) begin
      for (int i = 0; i < (W2 >> (l + 1)); i++) begin
        node[l+1][i] = node[l][2*i] +
                       node[l][2*i+1];
      end
    end
  end

  assign count = node[LV][0];

endmodule

// File: rtl/gol_monitor.sv
// Game-of-Life snapshot observer.
// Reports population, generation and terminal status.
module gol_monitor
  import gol_pkg::*;
#(
  parameter int ROWS  = 3,
  parameter int COLS  = 3,
  parameter int GEN_W = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ROWS-1:0][COLS-1:0]    grid,
  input  logic                         grid_valid,
  input  logic                         restart,
  output logic [pop_w(ROWS,COLS)-1:0]  population,
  output logic [GEN_W-1:0]             generation,
  output status_t                      status,
  output logic                         done,
  output logic                         gen_sat
);

  localparam int N  = ROWS * COLS;
  localparam int PW = pop_w(ROWS, COLS);
  localparam logic [GEN_W-1:0] GMAX = '1;

  typedef logic [N-1:0] cells_t;

  cells_t           cur;
  logic [PW-1:0]    cnt;

  status_t          status_q, status_d;
  logic [PW-1:0]    pop_q, pop_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             done_q, done_d;
  logic             sat_q, sat_d;
  cells_t           p1_q, p1_d;
  cells_t           p2_q, p2_d;
  logic             p1v_q, p1v_d;
  logic             p2v_q, p2v_d;

  logic             accept;
  logic             h1v, h2v;
  status_t          st_n;

  assign cur = grid;

  gol_popcount #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_pop (
    .bits  (cur),
    .count (cnt)
  );

  // Restart wipes history, then a sample may be taken.
  always_comb begin
    status_d = status_q;
    pop_d    = pop_q;
    gen_d    = gen_q;
    done_d   = done_q;
    sat_d    = sat_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    p1v_d    = p1v_q;
    p2v_d    = p2v_q;
    h1v      = p1v_q && !restart;
    h2v      = p2v_q && !restart;
    st_n     = RUN;
    accept   = grid_valid &&
               (restart || !is_term(status_q));

    if (restart) begin
      status_d = IDLE;
      pop_d    = '0;
      gen_d    = '0;
      done_d   = 1'b0;
      sat_d    = 1'b0;
      p1_d     = '0;
      p2_d     = '0;
      p1v_d    = 1'b0;
      p2v_d    = 1'b0;
    end

    if (accept) begin
      if (cnt == '0) begin
        st_n = DEAD;
      end else if (h1v && cur == p1_q) begin
        st_n = STILL;
      end else if (h2v && cur == p2_q) begin
        st_n = OSC2;
      end else begin
        st_n = RUN;
      end

      if (!h1v) begin
        gen_d = '0;
      end else if (gen_q != GMAX) begin
        gen_d = gen_q + 1'b1;
      end else begin
        gen_d = gen_q;
      end

      if (h1v && gen_d == GMAX) begin
        sat_d = 1'b1;
      end

      status_d = st_n;
      pop_d    = cnt;
      done_d   = is_term(st_n);
      p2_d     = h1v ? p1_q : '0;
      p2v_d    = h1v;
      p1_d     = cur;
      p1v_d    = 1'b1;
    end
  end

  // State and history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      status_q <= IDLE;
      pop_q    <= '0;
      gen_q    <= '0;
      done_q   <= 1'b0;
      sat_q    <= 1'b0;
      p1_q     <= '0;
      p2_q     <= '0;
      p1v_q    <= 1'b0;
      p2v_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      pop_q    <= pop_d;
      gen_q    <= gen_d;
      done_q   <= done_d;
      sat_q    <= sat_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      p1v_q    <= p1v_d;
      p2v_q    <= p2v_d;
    end
  end

  assign population = pop_q;
  assign generation = gen_q;
  assign status     = status_q;
  assign done       = done_q;
  assign gen_sat    = sat_q;

endmodule

// File: tb/tb_gol_monitor.sv
// Bench for gol_monitor: directed plan plus random
// traffic against a history-queue reference model.
module tb_gol_monitor;
  import gol_pkg::*;

  logic             clk;
  logic             reset;
  logic [2:0][2:0]  grid;
  logic             grid_valid;
  logic             restart;

  logic [3:0]       pop8, pop2;
  logic [7:0]       gen8;
  logic [1:0]       gen2;
  status_t          st8, st2;
  logic             done8, done2;
  logic             sat8, sat2;

  int checks = 0;
  int errors = 0;

  int m_st;
  int m_pop;
  int m_gen [2];
  int m_sat [2];
  int gmax  [2];
  logic [8:0] hist [$];

  localparam logic [8:0] PA  = 9'h092;
  localparam logic [8:0] PB  = 9'h038;
  localparam logic [8:0] BLK = 9'h01B;
  localparam logic [8:0] P5  = 9'h155;

  gol_monitor #(
    .ROWS(3), .COLS(3), .GEN_W(8)
  ) dut8 (
    .clk        (clk),
    .reset      (reset),
    .grid       (grid),
    .grid_valid (grid_valid),
    .restart    (restart),
    .population (pop8),
    .generation (gen8),
    .status     (st8),
    .done       (done8),
    .gen_sat    (sat8)
  );

  gol_monitor #(
    .ROWS(3), .COLS(3), .GEN_W(2)
  ) dut2 (
    .clk        (clk),
    .reset      (reset),
    .grid       (grid),
    .grid_valid (grid_valid),
    .restart    (restart),
    .population (pop2),
    .generation (gen2),
    .status     (st2),
    .done       (done2),
    .gen_sat    (sat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  function automatic bit term(input int s);
    return s == int'(DEAD) || s == int'(STILL) ||
           s == int'(OSC2);
  endfunction

  task automatic model(
    input logic [8:0] g,
    input bit v, input bit r, input bit rs
  );
    int p, ns, n;
    if (rs || r) begin
      hist.delete();
      m_st  = int'(IDLE);
      m_pop = 0;
      for (int k = 0; k < 2; k++) begin
        m_gen[k] = 0;
        m_sat[k] = 0;
      end
    end
    if (!rs && v && !term(m_st)) begin
      p = $countones(g);
      n = hist.size();
      if (p == 0)
        ns = int'(DEAD);
      else if (n > 0 && hist[n-1] == g)
        ns = int'(STILL);
      else if (n > 1 && hist[n-2] == g)
        ns = int'(OSC2);
      else
        ns = int'(RUN);
      for (int k = 0; k < 2; k++) begin
        if (n == 0) begin
          m_gen[k] = 0;
        end else begin
          if (m_gen[k] < gmax[k]) m_gen[k]++;
          if (m_gen[k] == gmax[k]) m_sat[k] = 1;
        end
      end
      m_st  = ns;
      m_pop = p;
      hist.push_back(g);
      if (hist.size() > 2) void'(hist.pop_front());
    end
  endtask

  task automatic compare();
    check("st8",   32'(st8),   32'(m_st));
    check("pop8",  32'(pop8),  32'(m_pop));
    check("gen8",  32'(gen8),  32'(m_gen[0]));
    check("sat8",  32'(sat8),  32'(m_sat[0]));
    check("done8", 32'(done8), 32'(term(m_st)));
    check("st2",   32'(st2),   32'(m_st));
    check("pop2",  32'(pop2),  32'(m_pop));
    check("gen2",  32'(gen2),  32'(m_gen[1]));
    check("sat2",  32'(sat2),  32'(m_sat[1]));
    check("done2", 32'(done2), 32'(term(m_st)));
  endtask

  task automatic cyc(
    input logic [8:0] g,
    input bit v, input bit r, input bit rs
  );
    grid       = g;
    grid_valid = v;
    restart    = r;
    reset      = rs;
    @(posedge clk);
    #1;
    model(g, v, r, rs);
    compare();
  endtask

  initial begin
    logic [8:0] g;
    int sel;
    bit v, r, rs;

    gmax[0] = 255;
    gmax[1] = 3;
    m_st = 0;
    m_pop = 0;
    m_gen[0] = 0; m_gen[1] = 0;
    m_sat[0] = 0; m_sat[1] = 0;
    grid = '0;
    grid_valid = 1'b0;
    restart = 1'b0;
    reset = 1'b1;

    cyc(9'h0, 0, 0, 1);
    cyc(9'h0, 0, 0, 1);
    check("rst_st",   32'(st8),   32'(IDLE));
    check("rst_pop",  32'(pop8),  0);
    check("rst_gen",  32'(gen8),  0);
    check("rst_done", 32'(done8), 0);
    check("rst_sat",  32'(sat8),  0);

    cyc(PA, 1, 0, 0);
    check("bl1_st",  32'(st8),  32'(RUN));
    check("bl1_pop", 32'(pop8), 3);
    check("bl1_gen", 32'(gen8), 0);
    cyc(PB, 1, 0, 0);
    check("bl2_st",  32'(st8),  32'(RUN));
    check("bl2_gen", 32'(gen8), 1);
    cyc(PA, 1, 0, 0);
    check("bl3_st",   32'(st8),   32'(OSC2));
    check("bl3_pop",  32'(pop8),  3);
    check("bl3_gen",  32'(gen8),  2);
    check("bl3_done", 32'(done8), 1);

    cyc(9'h0, 0, 1, 0);
    cyc(BLK, 1, 0, 0);
    cyc(BLK, 1, 0, 0);
    check("blk_st",   32'(st8),   32'(STILL));
    check("blk_pop",  32'(pop8),  4);
    check("blk_gen",  32'(gen8),  1);
    check("blk_done", 32'(done8), 1);

    cyc(9'h0, 0, 1, 0);
    cyc(9'h0, 1, 0, 0);
    check("dead_st",   32'(st8),   32'(DEAD));
    check("dead_pop",  32'(pop8),  0);
    check("dead_done", 32'(done8), 1);
    cyc(P5, 1, 0, 0);
    check("frz_st",  32'(st8),  32'(DEAD));
    check("frz_pop", 32'(pop8), 0);
    check("frz_gen", 32'(gen8), 0);
    cyc(PA, 1, 1, 0);
    check("rsv_st",   32'(st8),   32'(RUN));
    check("rsv_pop",  32'(pop8),  3);
    check("rsv_gen",  32'(gen8),  0);
    check("rsv_done", 32'(done8), 0);

    cyc(9'h0, 0, 1, 0);
    cyc(PA, 1, 0, 0);
    cyc(9'h0, 0, 0, 0);
    cyc(9'h001, 1, 0, 0);
    cyc(9'h0, 0, 0, 0);
    cyc(9'h003, 1, 0, 0);
    check("sat_pre", 32'(sat2), 0);
    cyc(9'h100, 1, 0, 0);
    check("sat_gen4", 32'(gen2), 3);
    check("sat_flag", 32'(sat2), 1);
    cyc(9'h0, 0, 0, 0);
    cyc(9'h010, 1, 0, 0);
    check("sat_gen5", 32'(gen2), 3);
    check("sat_st5",  32'(st2),  32'(RUN));

    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)
        g = '0;
      else if (sel <= 4 && hist.size() > 0)
        g = hist[$urandom_range(0, hist.size() - 1)];
      else
        g = 9'($urandom);
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 5) == 0);
      rs = ($urandom_range(0, 49) == 0);
      cyc(g, v, r, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
